hit_judge: RTL and testbench

HIT_JUDGE -- requirements
Module: hit_judge

---
 rtl/hit_judge.sv | 120 ++++++++++++
 tb/tb_hit_judge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// Reaction-game judge: arms on a one-hot LED target, then scores the first
// synchronized switch rise (or a timeout) as a hit or miss and keeps the statistics.
module hit_judge #(
    parameter int unsigned WINDOW = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  LED,
    input  logic [7:0]  sw,
    output logic        hit,
    output logic        miss,
    output logic [7:0]  score,
    output logic [7:0]  miss_count,
    output logic [7:0]  streak,
    output logic [7:0]  best_streak,
    output logic [24:0] react_time,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [24:0] LAST = 25'(WINDOW - 1);

    state_t      state;
    logic [7:0]  tgt;
    logic [24:0] timer;
    logic [7:0]  sw_m;
    logic [7:0]  sw_s;
    logic [7:0]  sw_p;

    logic [7:0]  rise;
    logic        led_one_hot;
    logic        wrong_rise;
    logic        tgt_rise;
    logic [7:0]  streak_next;

    always_comb begin
        rise        = sw_s & ~sw_p;
        led_one_hot = (LED != 8'd0) && ((LED & (LED - 8'd1)) == 8'd0);
        wrong_rise  = |(rise & ~tgt);
        tgt_rise    = (rise == tgt);
        streak_next = (streak == 8'hFF) ? 8'hFF : streak + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m <= 8'd0;
            sw_s <= 8'd0;
            sw_p <= 8'd0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
            sw_p <= sw_s;
        end
    end

    // hit/miss act as single-cycle valid strobes with no ready: the counters
    // they accompany are already updated in the same cycle the strobe is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tgt         <= 8'd0;
            timer       <= 25'd0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            score       <= 8'd0;
            miss_count  <= 8'd0;
            streak      <= 8'd0;
            best_streak <= 8'd0;
            react_time  <= 25'd0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                IDLE: begin
                    if (led_one_hot) begin
                        tgt   <= LED;
                        timer <= 25'd0;
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (wrong_rise) begin
                        miss       <= 1'b1;
                        miss_count <= (miss_count == 8'hFF) ? 8'hFF : miss_count + 8'd1;
                        streak     <= 8'd0;
                        state      <= COOLDOWN;
                    end else if (tgt_rise) begin
                        hit         <= 1'b1;
                        score       <= (score == 8'hFF) ? 8'hFF : score + 8'd1;
                        streak      <= streak_next;
                        react_time  <= timer;
                        best_streak <= (streak_next > best_streak) ? streak_next : best_streak;
                        state       <= COOLDOWN;
                    end else if (timer == LAST) begin
                        miss       <= 1'b1;
                        miss_count <= (miss_count == 8'hFF) ? 8'hFF : miss_count + 8'd1;
                        streak     <= 8'd0;
                        state      <= COOLDOWN;
                    end else begin
                        timer <= timer + 25'd1;
                    end
                end
                COOLDOWN: begin
                    // Wait for the player to let go and the target LED to move on.
                    if ((sw_s == 8'd0) && (LED != tgt))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hit_judge.sv
// Randomized bench for hit_judge: each round's outcome is predicted from its
// press delay and switch mask, queued, and matched against the observed pulses.
module tb_hit_judge;

  localparam int W = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  LED;
  logic [7:0]  sw;
  logic        hit;
  logic        miss;
  logic [7:0]  score;
  logic [7:0]  miss_count;
  logic [7:0]  streak;
  logic [7:0]  best_streak;
  logic [24:0] react_time;
  logic        busy;

  hit_judge #(.WINDOW(W)) dut (
    .clk(clk), .rst(rst), .LED(LED), .sw(sw),
    .hit(hit), .miss(miss), .score(score), .miss_count(miss_count),
    .streak(streak), .best_streak(best_streak), .react_time(react_time),
    .busy(busy)
  );

  typedef struct packed {
    logic        is_hit;
    logic [31:0] cyc;
    logic [7:0]  score;
    logic [7:0]  misses;
    logic [7:0]  streak;
    logic [7:0]  best;
    logic [24:0] react;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;

  // reference model state: plain unsaturated tallies
  int m_hits, m_miss, m_streak, m_best, m_react;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [7:0] sat(input int v);
    return (v > 255) ? 8'hFF : v[7:0];
  endfunction

  task automatic model_reset();
    m_hits = 0; m_miss = 0; m_streak = 0; m_best = 0; m_react = 0;
    exp_q.delete();
  endtask

  // The round's first switch rise reaches the judge d+2 cycles after arming;
  // a rise later than the window's last cycle loses to the timeout.
  task automatic predict(input logic [7:0] t, input logic [7:0] m, input int d, input int e0);
    int det;
    bit is_hit;
    exp_t e;
    if (m != 8'd0 && d + 2 <= W - 1) begin
      det = d + 2;
      is_hit = ((m & ~t) == 8'd0);
    end else begin
      det = W - 1;
      is_hit = 1'b0;
    end
    if (is_hit) begin
      m_hits++; m_streak++; m_react = det;
      if (m_streak > m_best) m_best = m_streak;
    end else begin
      m_miss++; m_streak = 0;
    end
    e.is_hit = is_hit;
    e.cyc    = 32'(e0 + det + 1);
    e.score  = sat(m_hits);
    e.misses = sat(m_miss);
    e.streak = sat(m_streak);
    e.best   = sat(m_best);
    e.react  = 25'(m_react);
    exp_q.push_back(e);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && (hit || miss)) begin
      if (hit && miss) check("hit_and_miss_together", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, hit, miss}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind_hit", 32'(hit), 32'(e.is_hit));
        check("pulse_cycle", cycle, e.cyc);
        check("score", 32'(score), 32'(e.score));
        check("miss_count", 32'(miss_count), 32'(e.misses));
        check("streak", 32'(streak), 32'(e.streak));
        check("best_streak", 32'(best_streak), 32'(e.best));
        check("react_time", 32'(react_time), 32'(e.react));
      end
    end
  end

  // driver tasks
  task automatic play(input logic [7:0] t, input logic [7:0] m, input int d, input bit chg);
    @(negedge clk);
    LED = t;
    predict(t, m, d, cycle + 1);
    @(negedge clk);
    if (chg) LED = 8'($urandom_range(0, 255));
    repeat (d) @(negedge clk);
    if (m != 8'd0) sw = m;
    repeat (20) @(negedge clk);
  endtask

  task automatic release_round();
    sw  = 8'd0;
    LED = 8'd0;
    repeat (4) @(negedge clk);
    check("idle_after_release", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hit"}, 32'(hit), 32'd0);
    check({tag, "_miss"}, 32'(miss), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_miss_count"}, 32'(miss_count), 32'd0);
    check({tag, "_streak"}, 32'(streak), 32'd0);
    check({tag, "_best"}, 32'(best_streak), 32'd0);
    check({tag, "_react"}, 32'(react_time), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] t, m;
    int kind, d;

    rst = 1'b1; LED = 8'd0; sw = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // multi-hot and zero targets never arm
    LED = 8'h03;
    repeat (5) @(negedge clk);
    check("multi_hot_ignored", 32'(busy), 32'd0);
    LED = 8'h00;
    repeat (3) @(negedge clk);
    check("zero_led_ignored", 32'(busy), 32'd0);

    play(8'h04, 8'h04, 4, 1'b0); release_round();   // timed hit
    play(8'h10, 8'h00, 0, 1'b0); release_round();   // timeout
    play(8'h01, 8'h09, 3, 1'b0); release_round();   // wrong + right together
    play(8'h20, 8'h20, 13, 1'b0); release_round();  // hit on the last window cycle

    // held switch with the target still lit keeps the judge in cooldown
    play(8'h02, 8'h02, 2, 1'b0);
    check("cooldown_held_sw", 32'(busy), 32'd1);
    sw = 8'd0;
    repeat (6) @(negedge clk);
    check("cooldown_led_still_lit", 32'(busy), 32'd1);
    LED = 8'd0;
    repeat (4) @(negedge clk);
    check("cooldown_exit", 32'(busy), 32'd0);

    // reset in the middle of an armed round
    @(negedge clk);
    LED = 8'h08;
    repeat (5) @(negedge clk);
    check("armed_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_zero("mid_round_reset");
    model_reset();
    LED = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sw = 8'h08;
    repeat (6) @(negedge clk);
    sw = 8'd0;
    repeat (4) @(negedge clk);
    check_zero("after_reset_idle_sw");

    // 3 hits, 1 miss, 1 hit
    play(8'h01, 8'h01, 1, 1'b0); release_round();
    play(8'h80, 8'h80, 6, 1'b1); release_round();
    play(8'h40, 8'h40, 0, 1'b0); release_round();
    play(8'h02, 8'h04, 2, 1'b0); release_round();
    play(8'h08, 8'h08, 9, 1'b0); release_round();
    check("seq_score", 32'(score), 32'd4);
    check("seq_miss_count", 32'(miss_count), 32'd1);
    check("seq_streak", 32'(streak), 32'd1);
    check("seq_best", 32'(best_streak), 32'd3);

    // randomized rounds
    for (int r = 0; r < 60; r++) begin
      t = 8'd1 << $urandom_range(0, 7);
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin m = t; d = $urandom_range(0, 13); end
        1: begin
          m = 8'($urandom_range(1, 255));
          if (m == t) m = m | ~t & 8'($urandom_range(1, 255)) | (t == 8'h01 ? 8'h02 : 8'h01);
          d = $urandom_range(0, 13);
        end
        2: begin m = 8'd0; d = 0; end
        default: begin m = t; d = $urandom_range(14, 18); end
      endcase
      play(t, m, d, 1'($urandom_range(0, 1)));
      release_round();
    end

    // saturation run
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 300; r++) begin
      t = 8'd1 << $urandom_range(0, 7);
      play(t, t, 0, 1'b0);
      release_round();
    end
    check("sat_score", 32'(score), 32'd255);
    check("sat_streak", 32'(streak), 32'd255);
    check("sat_best", 32'(best_streak), 32'd255);
    check("sat_miss_count", 32'(miss_count), 32'd0);

    repeat (4) @(negedge clk);
    check("pending_expectations", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
